// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, long-latency results are
// buffered in a small FIFO, a busy scoreboard tracks pending writes, and a WB bubble is requested on starvation.
module rf_wport_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mu_issue_valid,
    input  logic [REG_W-1:0]  mu_issue_rd,
    input  logic              mu_valid,
    input  logic [REG_W-1:0]  mu_rd,
    input  logic [DATA_W-1:0] mu_data,
    output logic              mu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_data,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy,
    output logic              wb_hold
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned NREG  = 2 ** REG_W;

    logic [REG_W-1:0]  r_fifo_rd   [BUF_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [SC_W-1:0]   r_starve;
    logic              r_hold;
    logic [NREG-1:0]   r_busy;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_wb_win;
    logic [REG_W-1:0]  w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic [NREG-1:0]   w_busy_nxt;

    assign w_empty     = (r_count == '0);
    assign mu_ready    = (r_count != CNT_W'(BUF_DEPTH));
    assign w_push      = mu_valid & mu_ready;
    assign w_wb_win    = wb_we & (wb_rd != '0);
    assign w_pop       = ~w_wb_win & ~w_empty;
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];
    assign wb_hold     = r_hold;

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        if (w_wb_win) begin
            rf_we   = 1'b1;
            rf_rd   = wb_rd;
            rf_data = wb_data;
        end else if (w_pop) begin
            rf_we   = (w_head_rd != '0);
            rf_rd   = w_head_rd;
            rf_data = w_head_data;
        end
    end

    // FIFO storage is not reset: the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mu_rd;
            r_fifo_data[r_wptr] <= mu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Hold pulses for one cycle after STARVE_MAX consecutive WB wins over a waiting result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else if (w_pop || w_empty || !w_wb_win) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else if (r_starve == SC_W'(STARVE_MAX - 1)) begin
            r_starve <= '0;
            r_hold   <= 1'b1;
        end else begin
            r_starve <= r_starve + 1'b1;
            r_hold   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue to the popped register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)
            w_busy_nxt[w_head_rd] = 1'b0;
        if (mu_issue_valid)
            w_busy_nxt[mu_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign rs1_busy = r_busy[id_rs1];
    assign rs2_busy = r_busy[id_rs2];
    assign rd_busy  = r_busy[id_rd];

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed-vector bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mu_issue_valid;
    logic [REG_W-1:0]  mu_issue_rd;
    logic              mu_valid;
    logic [REG_W-1:0]  mu_rd;
    logic [DATA_W-1:0] mu_data;
    logic              mu_ready;
    logic              rf_we;
    logic [REG_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              wb_hold;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    rf_wport_arbiter #(
        .DATA_W     (DATA_W),
        .REG_W      (REG_W),
        .BUF_DEPTH  (2),
        .STARVE_MAX (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mu_issue_valid (mu_issue_valid),
        .mu_issue_rd    (mu_issue_rd),
        .mu_valid       (mu_valid),
        .mu_rd          (mu_rd),
        .mu_data        (mu_data),
        .mu_ready       (mu_ready),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_data        (rf_data),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .rd_busy        (rd_busy),
        .wb_hold        (wb_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        mu_issue_valid = 1'b0; mu_issue_rd = '0;
        mu_valid = 1'b0; mu_rd = '0; mu_data = '0;
    endtask

    task automatic wb(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_we = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic mu(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
        mu_valid = 1'b1; mu_rd = rd; mu_data = d;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] d);
        chk({tag, "_we"}, 64'(rf_we), 64'(we));
        if (we) begin
            chk({tag, "_rd"},   64'(rf_rd),   64'(rd));
            chk({tag, "_data"}, 64'(rf_data), 64'(d));
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        #3;
        // 1: reset state
        chk("rst_mu_ready", 64'(mu_ready), 64'd1);
        chk("rst_rf_we",    64'(rf_we),    64'd0);
        chk("rst_rf_rd",    64'(rf_rd),    64'd0);
        chk("rst_rf_data",  64'(rf_data),  64'd0);
        chk("rst_busy",     64'({rs1_busy, rs2_busy, rd_busy}), 64'd0);
        chk("rst_hold",     64'(wb_hold),  64'd0);
        #2 rst = 1'b1;
        tick();
        wb(5, 32'hAA);
        #2 chk_rf("t1_wb", 1'b1, 5, 32'hAA);

        // 2: issue rd=7, result 3 cycles later
        tick(); idle_in();
        mu_issue_valid = 1'b1; mu_issue_rd = 7;
        tick(); idle_in(); id_rs1 = 7;
        #2 chk("t2_busy_a", 64'(rs1_busy), 64'd1);
        tick();
        tick(); mu(7, 32'h1234);
        #2 chk("t2_nobypass", 64'(rf_we), 64'd0);
        chk("t2_busy_b", 64'(rs1_busy), 64'd1);
        tick(); idle_in();
        #2 chk_rf("t2_write", 1'b1, 7, 32'h1234);
        chk("t2_busy_c", 64'(rs1_busy), 64'd1);
        tick();
        #2 chk("t2_busy_clr", 64'(rs1_busy), 64'd0);
        chk("t2_idle_we", 64'(rf_we), 64'd0);

        // 3: starvation -> one-cycle wb_hold
        tick(); wb(4, 32'h44); mu(3, 32'h33);
        #2 chk("t3_hold0", 64'(wb_hold), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(); idle_in(); wb(4, 32'h44);
            #2 chk($sformatf("t3_hold_w%0d", i), 64'(wb_hold), 64'd0);
            chk_rf($sformatf("t3_wb_w%0d", i), 1'b1, 4, 32'h44);
        end
        tick(); idle_in();
        #2 chk("t3_hold1", 64'(wb_hold), 64'd1);
        chk_rf("t3_pop", 1'b1, 3, 32'h33);
        tick();
        #2 chk("t3_hold_end", 64'(wb_hold), 64'd0);
        chk("t3_empty_we", 64'(rf_we), 64'd0);

        // 4: fill FIFO, backpressure, order
        tick(); wb(4, 32'h44); mu(10, 32'hA0);
        #2 chk("t4_rdy0", 64'(mu_ready), 64'd1);
        tick(); mu(11, 32'hB0);
        #2 chk("t4_rdy1", 64'(mu_ready), 64'd1);
        tick(); mu(12, 32'hC0);
        #2 chk("t4_full", 64'(mu_ready), 64'd0);
        tick(); wb_we = 1'b0;
        #2 chk("t4_full_pop", 64'(mu_ready), 64'd0);
        chk_rf("t4_pop10", 1'b1, 10, 32'hA0);
        tick();
        #2 chk("t4_rdy_again", 64'(mu_ready), 64'd1);
        chk_rf("t4_pop11", 1'b1, 11, 32'hB0);
        tick(); idle_in();
        #2 chk_rf("t4_pop12", 1'b1, 12, 32'hC0);
        tick();
        #2 chk("t4_drained", 64'(rf_we), 64'd0);

        // 5: same-cycle set/clear, x0 handling
        tick(); wb(4, 32'h44); mu_issue_valid = 1'b1; mu_issue_rd = 9;
        tick(); idle_in(); wb(4, 32'h44); mu(9, 32'h99);
        tick(); idle_in(); mu_issue_valid = 1'b1; mu_issue_rd = 9; id_rd = 9;
        #2 chk_rf("t5_pop9", 1'b1, 9, 32'h99);
        chk("t5_busy9_a", 64'(rd_busy), 64'd1);
        tick(); idle_in(); mu_issue_valid = 1'b1; mu_issue_rd = 0;
        #2 chk("t5_busy9_set_wins", 64'(rd_busy), 64'd1);
        tick(); idle_in(); id_rd = 0; mu(0, 32'h55);
        #2 chk("t5_busy0", 64'(rd_busy), 64'd0);
        tick(); idle_in();
        #2 chk("t5_x0_pop_we", 64'(rf_we), 64'd0);
        tick();
        #2 chk("t5_x0_popped", 64'(mu_ready), 64'd1);
        wb(0, 32'h77);
        #0 chk("t5_wb_x0_we", 64'(rf_we), 64'd0);

        // 6: reset mid-operation with two entries pending
        tick(); idle_in(); id_rs1 = 9; wb(4, 32'h44); mu(13, 32'hD0);
        tick(); mu(14, 32'hE0);
        tick(); idle_in();
        #1 chk("t6_full", 64'(mu_ready), 64'd0);
        chk("t6_busy9", 64'(rs1_busy), 64'd1);
        rst = 1'b0;
        #1 chk("t6_rst_rdy", 64'(mu_ready), 64'd1);
        chk("t6_rst_busy", 64'(rs1_busy), 64'd0);
        chk("t6_rst_we", 64'(rf_we), 64'd0);
        tick();
        #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2 chk($sformatf("t6_post_we%0d", i), 64'(rf_we), 64'd0);
            chk($sformatf("t6_post_rdy%0d", i), 64'(mu_ready), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
